// File: rtl/instqueue.sv
// instqueue: circular FIFO of fetched instructions and PCs that feeds the decoder one entry per cycle.
module instqueue #(
  parameter int DEPTH_LOG2   = 4,
  parameter int IDWidth      = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_full_out,
  input  logic                    RS_instqueue_stall_in,
  input  logic                    flush_in,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  logic [IDWidth-1:0]      inst_q [DEPTH];
  logic [AddressWidth-1:0] pc_q   [DEPTH];
  logic [DEPTH_LOG2-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    en_q, en_d;
  logic [IDWidth-1:0]      inst_out_q, inst_out_d;
  logic [AddressWidth-1:0] pc_out_q, pc_out_d;
  logic                    full, empty, push, pop, flush;
  always_comb begin
    full       = count_q == CW'(DEPTH);
    empty      = count_q == '0;
    flush      = rdy_in & flush_in;
    push       = rdy_in & !flush_in & if_instqueue_en_in & !full;
    pop        = rdy_in & !flush_in & !empty & !RS_instqueue_stall_in;
    head_d     = flush ? '0 : head_q + DEPTH_LOG2'(pop);
    tail_d     = flush ? '0 : tail_q + DEPTH_LOG2'(push);
    count_d    = flush ? '0 : count_q + CW'(push) - CW'(pop);
    en_d       = pop;
    inst_out_d = pop ? inst_q[head_q] : inst_out_q;
    pc_out_d   = pop ? pc_q[head_q] : pc_out_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      en_q       <= 1'b0;
      inst_out_q <= '0;
      pc_out_q   <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      en_q       <= en_d;
      inst_out_q <= inst_out_d;
      pc_out_q   <= pc_out_d;
    end
  end
  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_q[tail_q] <= if_instqueue_inst_in;
      pc_q[tail_q]   <= if_instqueue_pc_in;
    end
  end
  assign instqueue_if_full_out      = full;
  assign instqueue_decoder_en_out   = en_q;
  assign instqueue_decoder_inst_out = inst_out_q;
  assign instqueue_decoder_pc_out   = pc_out_q;
endmodule

// File: tb/tb_instqueue.sv
// tb_instqueue: directed scenario tasks for instqueue with hand-computed expectations.
module tb_instqueue;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1;
  logic        en_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] inst_in = '0, pc_in = '0;
  logic        full, en_out;
  logic [31:0] inst_out, pc_out;
  int          tests = 0, fails = 0;

  instqueue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_instqueue_en_in(en_in), .if_instqueue_inst_in(inst_in), .if_instqueue_pc_in(pc_in),
    .instqueue_if_full_out(full), .RS_instqueue_stall_in(stall), .flush_in(flush),
    .instqueue_decoder_en_out(en_out), .instqueue_decoder_inst_out(inst_out),
    .instqueue_decoder_pc_out(pc_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    tests++;
    if (en_out !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset: en=%b inst=%h pc=%h full=%b, want 0 0 0 0", en_out, inst_out, pc_out, full);
    end
  endtask

  task automatic test_basic_order;
    logic [31:0] insts [3];
    insts[0] = 32'h00000013; insts[1] = 32'h00100093; insts[2] = 32'h00200113;
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en_in = i < 3;
      inst_in = (i < 3) ? insts[i] : 32'h0;
      pc_in = 32'(i * 4);
      tick();
      tests++;
      if (i >= 1 && i <= 3) begin
        if (en_out !== 1'b1 || inst_out !== insts[i-1] || pc_out !== 32'((i - 1) * 4)) begin
          fails++;
          $display("FAIL basic_order[%0d]: en=%b inst=%h pc=%h, want 1 %h %h", i, en_out, inst_out, pc_out, insts[i-1], (i - 1) * 4);
        end
      end else if (en_out !== 1'b0) begin
        fails++;
        $display("FAIL basic_order_idle[%0d]: en=%b, want 0", i, en_out);
      end
    end
    en_in = 1'b0;
  endtask

  task automatic test_full_drop;
    stall = 1'b1;
    for (int i = 0; i < 17; i++) begin
      en_in = 1'b1;
      inst_in = 32'h1000 + 32'(i);
      pc_in = 32'(i * 4);
      tick();
      tests++;
      if (full !== (i >= 15) || en_out !== 1'b0) begin
        fails++;
        $display("FAIL full_fill[%0d]: full=%b en=%b, want %b 0", i, full, en_out, i >= 15);
      end
    end
    // Push presented while full is dropped even though a pop happens this cycle.
    stall = 1'b0;
    pc_in = 32'h999;
    for (int k = 0; k < 17; k++) begin
      tick();
      en_in = 1'b0;
      tests++;
      if (k < 16) begin
        if (en_out !== 1'b1 || pc_out !== 32'(k * 4) || inst_out !== 32'h1000 + 32'(k) || full !== 1'b0) begin
          fails++;
          $display("FAIL full_drain[%0d]: en=%b pc=%h inst=%h full=%b, want 1 %h %h 0", k, en_out, pc_out, inst_out, full, k * 4, 32'h1000 + k);
        end
      end else if (en_out !== 1'b0) begin
        fails++;
        $display("FAIL full_drop: en=%b pc=%h, want en 0", en_out, pc_out);
      end
    end
  endtask

  task automatic test_wrap_concurrent;
    stall = 1'b0;
    for (int i = 0; i <= 41; i++) begin
      en_in = i < 40;
      inst_in = 32'hA000 + 32'(i);
      pc_in = 32'h1000 + 32'(i * 4);
      tick();
      if (i >= 1 && i <= 40) begin
        tests++;
        if (en_out !== 1'b1 || pc_out !== 32'h1000 + 32'((i - 1) * 4) || inst_out !== 32'hA000 + 32'(i - 1) || full !== 1'b0) begin
          fails++;
          $display("FAIL wrap[%0d]: en=%b pc=%h inst=%h full=%b, want 1 %h %h 0", i, en_out, pc_out, inst_out, full, 32'h1000 + (i - 1) * 4, 32'hA000 + i - 1);
        end
      end else if (i == 41) begin
        tests++;
        if (en_out !== 1'b0) begin
          fails++;
          $display("FAIL wrap_end: en=%b, want 0", en_out);
        end
      end
    end
    en_in = 1'b0;
  endtask

  task automatic test_flush;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      en_in = 1'b1;
      inst_in = 32'hB000 + 32'(i);
      pc_in = 32'h500 + 32'(i * 4);
      tick();
    end
    flush = 1'b1;
    pc_in = 32'h100;
    inst_in = 32'hC100;
    tick();
    tests++;
    if (en_out !== 1'b0 || full !== 1'b0) begin
      fails++;
      $display("FAIL flush_edge: en=%b full=%b, want 0 0", en_out, full);
    end
    flush = 1'b0;
    stall = 1'b0;
    pc_in = 32'h200;
    inst_in = 32'hC200;
    tick();
    tests++;
    if (en_out !== 1'b0) begin
      fails++;
      $display("FAIL flush_nobypass: en=%b pc=%h, want en 0", en_out, pc_out);
    end
    en_in = 1'b0;
    tick();
    tests++;
    if (en_out !== 1'b1 || pc_out !== 32'h200 || inst_out !== 32'hC200) begin
      fails++;
      $display("FAIL flush_next: en=%b pc=%h inst=%h, want 1 00000200 0000c200", en_out, pc_out, inst_out);
    end
    tick();
    tests++;
    if (en_out !== 1'b0) begin
      fails++;
      $display("FAIL flush_stale: en=%b pc=%h, want en 0", en_out, pc_out);
    end
  endtask

  task automatic test_rdy_freeze;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en_in = 1'b1;
      inst_in = 32'hD000 + 32'(i);
      pc_in = 32'h600 + 32'(i * 4);
      tick();
    end
    rdy_in = 1'b0;
    stall = 1'b0;
    pc_in = 32'h6F0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (en_out !== 1'b0 || pc_out !== 32'h200) begin
        fails++;
        $display("FAIL rdy_freeze[%0d]: en=%b pc=%h, want 0 00000200", i, en_out, pc_out);
      end
    end
    rdy_in = 1'b1;
    en_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (k < 4) begin
        if (en_out !== 1'b1 || pc_out !== 32'h600 + 32'(k * 4) || inst_out !== 32'hD000 + 32'(k)) begin
          fails++;
          $display("FAIL rdy_resume[%0d]: en=%b pc=%h inst=%h, want 1 %h %h", k, en_out, pc_out, inst_out, 32'h600 + k * 4, 32'hD000 + k);
        end
      end else if (en_out !== 1'b0) begin
        fails++;
        $display("FAIL rdy_extra: en=%b pc=%h, want en 0", en_out, pc_out);
      end
    end
  endtask

  task automatic test_reset_mid;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en_in = 1'b1;
      inst_in = 32'hE000 + 32'(i);
      pc_in = 32'h700 + 32'(i * 4);
      tick();
    end
    en_in = 1'b0;
    stall = 1'b0;
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tests++;
    if (en_out !== 1'b0 || inst_out !== 32'h0 || pc_out !== 32'h0 || full !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: en=%b inst=%h pc=%h full=%b, want 0 0 0 0", en_out, inst_out, pc_out, full);
    end
    en_in = 1'b1;
    pc_in = 32'h300;
    inst_in = 32'hF300;
    tick();
    tests++;
    if (en_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_stale: en=%b pc=%h, want en 0", en_out, pc_out);
    end
    en_in = 1'b0;
    tick();
    tests++;
    if (en_out !== 1'b1 || pc_out !== 32'h300 || inst_out !== 32'hF300) begin
      fails++;
      $display("FAIL reset_push: en=%b pc=%h inst=%h, want 1 00000300 0000f300", en_out, pc_out, inst_out);
    end
    tick();
    tests++;
    if (en_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_after: en=%b pc=%h, want en 0", en_out, pc_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_full_drop();
    test_wrap_concurrent();
    test_flush();
    test_rdy_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
